serial_sub_10bit: RTL
=====================

SERIAL_SUB_10BIT -- requirements
Module: serial_sub_10bit

Interface
REQ-001 Parameter: WIDTH, default 10, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: Start  input  1  request to begin one subtraction; sampled on rising clk.
REQ-005 Port: A  input  WIDTH  minuend; sampled only when a Start is accepted.
REQ-006 Port: B  input  WIDTH  subtrahend; sampled only when a Start is accepted.
REQ-007 Port: Bin  input  1  borrow-in; sampled only when a Start is accepted.
REQ-008 Port: Ready  output  1  high only in IDLE; Start is accepted only while Ready=1.
REQ-009 Port: Busy  output  1  high in RUN and DONE.
REQ-010 Port: D  output  WIDTH  difference A-B-Bin, registered.
REQ-011 Port: Bout  output  1  borrow-out (unsigned A < B+Bin), registered.
REQ-012 Port: Ovf  output  1  two's-complement signed overflow of the subtraction, registered.
REQ-013 Port: Done  output  1  single-cycle pulse marking D/Bout/Ovf as newly valid.

Function
REQ-014 States: IDLE, RUN, DONE; state encoding is left to the implementation.
REQ-015 IDLE: Start=1 at a rising edge latches A, B and Bin into internal registers, clears the bit counter, and moves to RUN.
REQ-016 RUN: processes exactly one bit per cycle, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br starts at the latched Bin.
REQ-017 RUN: the result bit is shifted into a WIDTH-bit shift register; the counter increments from 0 to WIDTH-1.
REQ-018 RUN: at the edge that processes bit WIDTH-1, D is loaded with the full result, Bout with the final br, and Ovf with (a_msb != b_msb) & (d_msb != a_msb); state moves to DONE.
REQ-019 DONE: Done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-020 Latency: Start accepted at edge k; Done is high in the cycle after edge k+WIDTH; Ready is high again after edge k+WIDTH+1.
REQ-021 Throughput: one operation per WIDTH+2 cycles when Start is held high continuously.
REQ-022 Start while Busy=1 (RUN or DONE) is ignored without effect; A, B and Bin changes during RUN do not alter the result.
REQ-023 D, Bout and Ovf hold their last completed values until the next DONE entry and do not change during RUN.
REQ-024 Wrap-around: the result is modulo 2^WIDTH; e.g. 0-1 gives all ones with Bout=1.
REQ-025 Bin=1 with A=B gives D=all ones and Bout=1.

Reset
REQ-026 rst=1 immediately forces state=IDLE, Ready=1, Busy=0, Done=0, D=0, Bout=0, Ovf=0, counter=0 and clears the internal operand and shift registers, independent of clk.
REQ-027 rst asserted during RUN or DONE aborts the operation; no Done pulse is produced for the aborted operation.
REQ-028 After rst deasserts, a Start at the first rising edge is accepted normally.

Verification
REQ-029 A=0, B=1, Bin=0, Start pulse -> Done exactly 10 cycles after acceptance; D=10'h3FF, Bout=1, Ovf=0.
REQ-030 A=10'h200, B=10'h001, Bin=0 -> D=10'h1FF, Bout=0, Ovf=1. A=10'h1FF, B=10'h3FF -> D=10'h200, Bout=1, Ovf=1.
REQ-031 A=5, B=3, Bin=1 -> D=1, Bout=0, Ovf=0. A=7, B=7, Bin=1 -> D=10'h3FF, Bout=1.
REQ-032 Start A=9, B=4; re-pulse Start with A=1, B=2 at cycle 3 of RUN -> second Start ignored; single Done with D=5; then Ready=1.
REQ-033 Assert rst at cycle 5 of RUN -> outputs go to reset values at once; no Done appears; a fresh Start with A=2, B=2 then gives D=0, Bout=0.
REQ-034 Start held high for 3 operations -> Done pulses spaced exactly 12 cycles apart; all results are correct.

Source files
------------

// File: rtl/serial_sub_10bit.sv
// serial_sub_10bit: bit-serial LSB-first subtractor computing A-B-Bin with borrow-out and signed overflow
module serial_sub_10bit #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Ready,
    output logic             Busy,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Ovf,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, sr;
    logic [CW-1:0] cnt;
    logic br, a_i, b_i, d_i, br_nx, last;
    assign a_i   = a_r[0];
    assign b_i   = b_r[0];
    assign d_i   = a_i ^ b_i ^ br;
    assign br_nx = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    assign last  = cnt == CW'(WIDTH - 1);
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    // next state and status outputs
    always_comb begin
        state_nx = state == IDLE ? (Start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
        Ready    = state == IDLE;
        Busy     = state != IDLE;
        Done     = state == DONE;
    end
    // operand latch, one-bit-per-cycle datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            sr   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
            Ovf  <= 1'b0;
        end else if (state == IDLE && Start) begin
            a_r <= A;
            b_r <= B;
            br  <= Bin;
            cnt <= '0;
        end else if (state == RUN) begin
            a_r <= a_r >> 1;
            b_r <= b_r >> 1;
            br  <= br_nx;
            cnt <= cnt + CW'(1);
            sr  <= {d_i, sr[WIDTH-1:1]};
            if (last) begin
                D    <= {d_i, sr[WIDTH-1:1]};
                Bout <= br_nx;
                Ovf  <= (a_i != b_i) & (d_i != a_i);
            end
        end
    end
endmodule
